// File: rtl/multicycle_mem_bridge_if.sv
// Valid/ready memory bus between the multicycle memory bridge and the memory system.
interface multicycle_mem_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/multicycle_mem_bridge.sv
// Memory port of the multicycle core: controller enables become valid/ready bus accesses.
// Define MEM_BRIDGE_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES on the bus.
module multicycle_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic        inst_or_data,
    input  logic [31:0] pc,
    input  logic [31:0] data_addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  inst_funct3,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        misaligned,
    output logic        bus_error,
    multicycle_mem_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic        we_q, mis_q;

    logic        capture, rsp_take, abort, timeout;
    logic [31:0] access_addr, wdata_aligned, load_data;
    logic [3:0]  wstrb_aligned;
    logic [2:0]  access_funct3;
    logic        access_mis;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    // Fetches are always whole words regardless of what funct3 happens to hold.
    always_comb begin
        access_addr   = inst_or_data ? data_addr : pc;
        access_funct3 = inst_or_data ? inst_funct3 : 3'b010;
        wdata_aligned = store_data;
        wstrb_aligned = 4'b1111;
        access_mis    = 1'b0;
        case (access_funct3[1:0])
            2'b00: begin
                wdata_aligned = {4{store_data[7:0]}};
                wstrb_aligned = 4'b0001 << access_addr[1:0];
            end
            2'b01: begin
                wdata_aligned = {2{store_data[15:0]}};
                wstrb_aligned = 4'b0011 << access_addr[1:0];
                access_mis    = access_addr[0];
            end
            default: access_mis = |access_addr[1:0];
        endcase
    end

    always_comb begin
        rsp_byte  = bus.bus_rsp_rdata[{addr_q[1:0], 3'b000} +: 8];
        rsp_half  = bus.bus_rsp_rdata[{addr_q[1], 4'b0000} +: 16];
        load_data = bus.bus_rsp_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{rsp_byte[7]}}, rsp_byte};
            3'b001:  load_data = {{16{rsp_half[15]}}, rsp_half};
            3'b100:  load_data = {24'h0, rsp_byte};
            3'b101:  load_data = {16'h0, rsp_half};
            default: load_data = bus.bus_rsp_rdata;
        endcase
    end

    // NOTE: every always_comb output is given a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        capture    = 1'b0;
        rsp_take   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read_enable || mem_write_enable) begin
                    mem_stall  = 1'b1;
                    capture    = 1'b1;
                    state_next = access_mis ? DONE : REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (bus.bus_req_ready) begin
                    rsp_take   = bus.bus_rsp_valid;
                    state_next = bus.bus_rsp_valid ? DONE : WAIT_RSP;
                end else if (timeout) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_RSP: begin
                mem_stall = 1'b1;
                if (bus.bus_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = DONE;
                end else if (timeout) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q   <= access_addr;
                funct3_q <= access_funct3;
                we_q     <= mem_write_enable;
                mis_q    <= access_mis;
                wdata_q  <= mem_write_enable ? wdata_aligned : 32'h0;
                wstrb_q  <= mem_write_enable ? wstrb_aligned : 4'h0;
            end
            if (capture && access_mis && !mem_write_enable) begin
                mem_rdata <= '0;
            end else if (rsp_take && !we_q) begin
                mem_rdata <= load_data;
            end else if (abort) begin
                mem_rdata <= '0;
            end
        end
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The count is zero in the first REQ cycle, so the last permitted wait cycle is TIMEOUT_CYCLES-1.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == REQ || state == WAIT_RSP) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                   wait_cnt <= '0;
            if (capture)    err_q <= 1'b0;
            else if (abort) err_q <= 1'b1;
        end
    end

    assign bus_error = (state == DONE) && err_q;
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
    assign bus_error          = 1'b0;
`endif

    assign misaligned        = (state == DONE) && mis_q;
    assign bus.bus_req_valid = (state == REQ);
    assign bus.bus_req_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_req_we    = we_q;
    assign bus.bus_req_wdata = wdata_q;
    assign bus.bus_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_multicycle_mem_bridge.sv
// Scoreboard bench for multicycle_mem_bridge: directed accesses against a scripted bus responder.
module tb_multicycle_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 255;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read_enable = 1'b0;
    logic        mem_write_enable = 1'b0;
    logic        inst_or_data = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] store_data = '0;
    logic [2:0]  inst_funct3 = '0;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        misaligned;
    logic        bus_error;

    multicycle_mem_bridge_if bus_if ();

    multicycle_mem_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .inst_or_data     (inst_or_data),
        .pc               (pc),
        .data_addr        (data_addr),
        .store_data       (store_data),
        .inst_funct3      (inst_funct3),
        .mem_stall        (mem_stall),
        .mem_rdata        (mem_rdata),
        .misaligned       (misaligned),
        .bus_error        (bus_error),
        .bus              (bus_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_exp_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          stalls;
    } cmp_exp_t;

    req_exp_t req_q[$];
    cmp_exp_t cmp_q[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cfg_ready_wait = 0;
    int          cfg_rsp_delay = 0;
    logic [31:0] cfg_word = '0;
    int          inject_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Bus responder: ready after cfg_ready_wait REQ cycles, response cfg_rsp_delay cycles after acceptance.
    initial begin
        int w = 0;
        int d = 0;
        int phase = 0;
        int inj_done = 0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_rdata = '0;
        forever begin
            @(negedge clock);
            bus_if.bus_req_ready = 1'b0;
            bus_if.bus_rsp_valid = 1'b0;
            bus_if.bus_rsp_rdata = '0;
            if (!reset_n) begin
                phase = 0;
                w = 0;
            end else if (inject_req != inj_done) begin
                inj_done++;
                bus_if.bus_rsp_valid = 1'b1;
                bus_if.bus_rsp_rdata = 32'hBAD0_BAD0;
            end else if (phase == 1) begin
                d++;
                if (d >= cfg_rsp_delay) begin
                    bus_if.bus_rsp_valid = 1'b1;
                    bus_if.bus_rsp_rdata = cfg_word;
                    phase = 0;
                end
            end else if (bus_if.bus_req_valid) begin
                if (w >= cfg_ready_wait) begin
                    bus_if.bus_req_ready = 1'b1;
                    w = 0;
                    if (cfg_rsp_delay == 0) begin
                        bus_if.bus_rsp_valid = 1'b1;
                        bus_if.bus_rsp_rdata = cfg_word;
                    end else begin
                        phase = 1;
                        d = 0;
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Monitor: checks accepted requests and completed accesses against the scoreboard queues.
    initial begin
        int stalls = 0;
        req_exp_t r;
        cmp_exp_t c;
        forever begin
            @(negedge clock);
            #2;
            if (!reset_n) begin
                stalls = 0;
            end else begin
                if (bus_if.bus_req_valid && bus_if.bus_req_ready) begin
                    check("req_expected", 32'(req_q.size() != 0), 32'd1);
                    if (req_q.size() != 0) begin
                        r = req_q.pop_front();
                        check({r.name, "/addr"}, bus_if.bus_req_addr, r.addr);
                        check({r.name, "/we"}, 32'(bus_if.bus_req_we), 32'(r.we));
                        check({r.name, "/wstrb"}, 32'(bus_if.bus_req_wstrb), 32'(r.wstrb));
                        if (r.we) check({r.name, "/wdata"}, bus_if.bus_req_wdata, r.wdata);
                    end
                end
                if (mem_stall) begin
                    stalls++;
                end else if (stalls > 0) begin
                    check("cmp_expected", 32'(cmp_q.size() != 0), 32'd1);
                    if (cmp_q.size() != 0) begin
                        c = cmp_q.pop_front();
                        check({c.name, "/mem_rdata"}, mem_rdata, c.rdata);
                        check({c.name, "/misaligned"}, 32'(misaligned), 32'(c.mis));
                        check({c.name, "/bus_error"}, 32'(bus_error), 32'(c.err));
                        check({c.name, "/stall_cycles"}, 32'(stalls), 32'(c.stalls));
                    end
                    stalls = 0;
                end else begin
                    check("idle_pulses", {30'h0, misaligned, bus_error}, 32'h0);
                end
            end
        end
    end

    task automatic run_vec(input string name, input logic re, input logic we, input logic iod,
                           input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                           input int rw, input int rd, input logic [31:0] word,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [3:0] e_wstrb, input logic [31:0] e_rdata,
                           input logic e_mis, input logic e_err, input int e_stalls);
        logic done;
        cfg_ready_wait = rw;
        cfg_rsp_delay  = rd;
        cfg_word       = word;
        if (!e_mis && !e_err) req_q.push_back('{name, e_addr, we, e_wdata, e_wstrb});
        cmp_q.push_back('{name, e_rdata, e_mis, e_err, e_stalls});
        @(negedge clock);
        mem_read_enable  = re;
        mem_write_enable = we;
        inst_or_data     = iod;
        pc               = iod ? 32'hDEAD_0000 : addr;
        data_addr        = iod ? addr : 32'hBEEF_0004;
        store_data       = rs2;
        inst_funct3      = f3;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            #1;
            if (!mem_stall) done = 1'b1;
        end
        check({name, "/completed"}, 32'(done), 32'd1);
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/mem_stall"}, 32'(mem_stall), 32'h0);
        check({tag, "/mem_rdata"}, mem_rdata, 32'h0);
        check({tag, "/misaligned"}, 32'(misaligned), 32'h0);
        check({tag, "/bus_error"}, 32'(bus_error), 32'h0);
        check({tag, "/req_valid"}, 32'(bus_if.bus_req_valid), 32'h0);
        check({tag, "/req_addr"}, bus_if.bus_req_addr, 32'h0);
        check({tag, "/req_we"}, 32'(bus_if.bus_req_we), 32'h0);
        check({tag, "/req_wdata"}, bus_if.bus_req_wdata, 32'h0);
        check({tag, "/req_wstrb"}, 32'(bus_if.bus_req_wstrb), 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        //      name              re    we    iod   addr        rs2           f3     rw rd word          e_addr      e_wdata       e_wstrb  e_rdata       mis   err   stalls
        run_vec("fetch_0x100",    1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        3'd0, 0, 0, 32'h00500093, 32'h100, 32'h0,        4'h0, 32'h00500093, 1'b0, 1'b0, 2);
        run_vec("lb_0x203",       1'b1, 1'b0, 1'b1, 32'h203, 32'h0,        3'd0, 2, 3, 32'h80FFFFFF, 32'h200, 32'h0,        4'h0, 32'hFFFFFF80, 1'b0, 1'b0, 7);
        run_vec("sh_0x302",       1'b0, 1'b1, 1'b1, 32'h302, 32'h1234ABCD, 3'd1, 0, 1, 32'h0,        32'h300, 32'hABCDABCD, 4'hC, 32'hFFFFFF80, 1'b0, 1'b0, 3);
        run_vec("lw_mis_0x401",   1'b1, 1'b0, 1'b1, 32'h401, 32'h0,        3'd2, 0, 0, 32'h0,        32'h0,   32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1);
        run_vec("lh_0x602",       1'b1, 1'b0, 1'b1, 32'h602, 32'h0,        3'd1, 1, 0, 32'h80011234, 32'h600, 32'h0,        4'h0, 32'hFFFF8001, 1'b0, 1'b0, 3);
        run_vec("lhu_0x602",      1'b1, 1'b0, 1'b1, 32'h602, 32'h0,        3'd5, 0, 2, 32'h80011234, 32'h600, 32'h0,        4'h0, 32'h00008001, 1'b0, 1'b0, 4);
        run_vec("lbu_0x701",      1'b1, 1'b0, 1'b1, 32'h701, 32'h0,        3'd4, 0, 0, 32'h00009A00, 32'h700, 32'h0,        4'h0, 32'h0000009A, 1'b0, 1'b0, 2);
        run_vec("sb_0x803",       1'b0, 1'b1, 1'b1, 32'h803, 32'h000000EE, 3'd0, 0, 0, 32'h0,        32'h800, 32'hEEEEEEEE, 4'h8, 32'h0000009A, 1'b0, 1'b0, 2);
        run_vec("sw_0x900",       1'b0, 1'b1, 1'b1, 32'h900, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0,        32'h900, 32'hDEADBEEF, 4'hF, 32'h0000009A, 1'b0, 1'b0, 2);
        run_vec("sh_mis_0x301",   1'b0, 1'b1, 1'b1, 32'h301, 32'h00005555, 3'd1, 0, 0, 32'h0,        32'h0,   32'h0,        4'h0, 32'h0000009A, 1'b1, 1'b0, 1);
        run_vec("fetch_mis_0x102",1'b1, 1'b0, 1'b0, 32'h102, 32'h0,        3'd0, 0, 0, 32'h0,        32'h0,   32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1);
        run_vec("rw_both_0xa04",  1'b1, 1'b1, 1'b1, 32'hA04, 32'h11223344, 3'd2, 0, 0, 32'h0,        32'hA04, 32'h11223344, 4'hF, 32'h0,        1'b0, 1'b0, 2);
        run_vec("lb_0xb02",       1'b1, 1'b0, 1'b1, 32'hB02, 32'h0,        3'd0, 0, 0, 32'h00770000, 32'hB00, 32'h0,        4'h0, 32'h00000077, 1'b0, 1'b0, 2);
        run_vec("lw_0xc00",       1'b1, 1'b0, 1'b1, 32'hC00, 32'h0,        3'd2, 1, 1, 32'hCAFEF00D, 32'hC00, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 4);

        // Reset while the bridge waits for a response; the late response must be ignored.
        cfg_ready_wait = 0;
        cfg_rsp_delay  = 1000;
        cfg_word       = 32'h12345678;
        req_q.push_back('{"rst_lw_0x500", 32'h500, 1'b0, 32'h0, 4'h0});
        @(negedge clock);
        mem_read_enable = 1'b1;
        inst_or_data    = 1'b1;
        data_addr       = 32'h500;
        inst_funct3     = 3'd2;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_lw/stall_in_wait", 32'(mem_stall), 32'h1);
        reset_n         = 1'b0;
        mem_read_enable = 1'b0;
        @(negedge clock);
        #1;
        check_reset_state("mid_reset");
        @(negedge clock);
        #1;
        reset_n       = 1'b1;
        cfg_rsp_delay = 0;
        inject_req++;
        repeat (2) @(negedge clock);
        #1;
        check("late_rsp/mem_rdata", mem_rdata, 32'h0);
        check("late_rsp/mem_stall", 32'(mem_stall), 32'h0);
        check("late_rsp/req_valid", 32'(bus_if.bus_req_valid), 32'h0);
        run_vec("fetch_after_rst",1'b1, 1'b0, 1'b0, 32'h104, 32'h0,        3'd0, 0, 0, 32'h00A00113, 32'h104, 32'h0,        4'h0, 32'h00A00113, 1'b0, 1'b0, 2);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        run_vec("lw_timeout",     1'b1, 1'b0, 1'b1, 32'hD00, 32'h0,        3'd2, 1000, 0, 32'h0,     32'hD00, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 5);
        run_vec("fetch_after_to", 1'b1, 1'b0, 1'b0, 32'h108, 32'h0,        3'd0, 0, 0, 32'h00000013, 32'h108, 32'h0,        4'h0, 32'h00000013, 1'b0, 1'b0, 2);
`endif

        repeat (4) @(negedge clock);
        #3;
        check("req_queue_drained", 32'(req_q.size()), 32'h0);
        check("cmp_queue_drained", 32'(cmp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
